key_event_gen: RTL and testbench

KEY_EVENT_GEN -- requirements
Module: key_event_gen

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/key_event_gen_if.sv | 12 +
 rtl/key_debounce.sv | 140 ++++++++++++++
 rtl/key_event_gen.sv | 72 +++++++
 tb/tb_key_event_gen.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the key event block.
// Holds the key index constants, the per-key debounce FSM state encoding,
// the default timing constants and a counter-width helper.
package lcd_pkg;

  // Bit positions inside key_n / key_level / evt_key
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 0;
  localparam int NUM_KEYS  = 4;

  // Default timing at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1048576;   // ~21 ms
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int DEF_REPEAT_PERIOD   = 10000000;  // 0.2 s

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } key_state_t;

  // Bits needed to hold n-1 without wrap
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Event handshake between key_event_gen (master) and its consumer (slave).
//   evt_valid : an event is pending in the slot
//   evt_key   : one-hot key of the pending event, 0 when evt_valid=0
//   evt_ack   : consumer accepts the pending event
interface key_event_gen_if;
  logic       evt_valid;
  logic [3:0] evt_key;
  logic       evt_ack;

  modport master (output evt_valid, output evt_key, input evt_ack);
  modport slave  (input evt_valid, input evt_key, output evt_ack);
endinterface

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer, debounce FSM and counter,
// optional auto-repeat timer.
// Optional feature macro: KEY_EVT_AUTOREPEAT_EN (repeat events while held).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   key_n    : raw active-low button, asynchronous
//   level    : debounced pressed state
//   raise    : one-cycle pulse requesting an event (press or repeat)
// DEBOUNCE_CYCLES must be at least 2.
module key_debounce import lcd_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic raise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("key_debounce: unsupported timing parameters");
  end

  logic          sync1, sync2;
  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press;

  // Synchronizer clears to the released level so that a post-reset press
  // always needs a full debounce interval of genuine low samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The sample that leaves IDLE/HELD is the first stable sample, so the
  // counter is loaded with 1 there; the terminal test at CNT_LAST then
  // accepts on exactly DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!sync2) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (sync2) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (sync2) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync2) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == ST_HELD) || (state == ST_RELEASE_WAIT);

`ifdef KEY_EVT_AUTOREPEAT_EN
  localparam int             RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int             RW       = cnt_width(RPT_MAX);
  localparam logic [RW-1:0]  DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;  // still waiting for the initial delay
  logic          rpt_hit;

  assign rpt_hit = (state == ST_HELD) && (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST));

  // Restarts on a fresh press; holds its value through RELEASE_WAIT.
  always_ff @(posedge clk) begin
    if (rst || press) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state == ST_HELD) begin
      if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign raise = press | rpt_hit;
`else
  assign raise = press;
`endif

endmodule

// File: rtl/key_event_gen.sv
// Four-button event generator: per-key debounce, fixed-priority arbitration
// (up > down > left > right) into a one-entry event slot, saturating count
// of dropped events.
// Optional feature macro: KEY_EVT_AUTOREPEAT_EN (auto-repeat while held).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   key_n     : raw buttons {up,down,left,right}, active-low, asynchronous
//   key_level : debounced pressed state, active-high
//   drop_cnt  : events lost to a full slot, saturates at 255
//   evt       : event slot handshake (master side)
module key_event_gen import lcd_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  key_n,
  output logic [NUM_KEYS-1:0]  key_level,
  output logic [7:0]           drop_cnt,
  key_event_gen_if.master      evt
);

  logic [NUM_KEYS-1:0] raise;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[i]),
      .level (key_level[i]),
      .raise (raise[i])
    );
  end

  logic [NUM_KEYS-1:0] grant;
  logic                slot_free;
  logic [2:0]          n_raise, n_drop;
  logic [8:0]          drop_sum;

  always_comb begin
    grant = '0;
    if      (raise[KEY_UP])    grant[KEY_UP]    = 1'b1;
    else if (raise[KEY_DOWN])  grant[KEY_DOWN]  = 1'b1;
    else if (raise[KEY_LEFT])  grant[KEY_LEFT]  = 1'b1;
    else if (raise[KEY_RIGHT]) grant[KEY_RIGHT] = 1'b1;
    // An ack in the same cycle frees the slot for a zero-bubble reload.
    slot_free = !evt.evt_valid || evt.evt_ack;
    n_raise   = 3'($countones(raise));
    n_drop    = (slot_free && (raise != '0)) ? n_raise - 3'd1 : n_raise;
    drop_sum  = {1'b0, drop_cnt} + {6'b0, n_drop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      drop_cnt      <= '0;
    end else begin
      if (slot_free) begin
        evt.evt_valid <= |raise;
        evt.evt_key   <= grant;
      end
      drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: directed scenarios plus randomized key/ack/reset
// traffic, all checked against a window-based reference model; loaded events
// go through a scoreboard queue compared by an independent monitor.
module tb_key_event_gen;
  import lcd_pkg::*;

  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 6;
`ifdef KEY_EVT_AUTOREPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_level;
  logic [7:0] drop_cnt;

  key_event_gen_if ev();

  key_event_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_level (key_level),
    .drop_cnt  (drop_cnt),
    .evt       (ev)
  );

  always #5 clk = ~clk;

  int unsigned edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned at;
    logic [3:0]  key;
  } exp_t;
  exp_t exp_q[$];

  // Reference model. A key's accepted level flips once DB consecutive
  // synchronized samples disagree with it; a held key (level 1, no pending
  // release samples) accumulates held cycles for auto-repeat.
  logic [3:0] m_level = '0;
  int         m_run[4];
  int         m_hold[4];
  logic [3:0] m_d1 = 4'hF, m_d2 = 4'hF;
  logic       m_valid = 1'b0;
  logic [3:0] m_key = '0;
  int         m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_no);
    end
  endtask

  task automatic model_step(input logic [3:0] kn, input logic ack, input logic r);
    logic [3:0] rs;
    int         n;
    logic       pr;
    bit         can;
    exp_t       e;
    if (r) begin
      m_level = '0; m_valid = 1'b0; m_key = '0; m_drop = 0;
      m_d1 = 4'hF; m_d2 = 4'hF;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_hold[i] = 0; end
      exp_q.delete();
      return;
    end
    rs = '0;
    for (int i = 0; i < 4; i++) begin
      pr = !m_d2[i];
      if (m_level[i] && m_run[i] == 0) begin
        m_hold[i]++;
        if (RPT_EN && m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) rs[i] = 1'b1;
      end
      if (pr != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_level[i] = pr;
          m_run[i]   = 0;
          m_hold[i]  = 0;
          if (pr) rs[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = kn;
    n   = $countones(rs);
    can = !m_valid || ack;
    if (m_valid && ack) begin m_valid = 1'b0; m_key = '0; end
    if (n > 0 && can) begin
      for (int i = 0; i < 4; i++) if (rs[i]) m_key = 4'(1 << i);  // highest index wins
      m_valid = 1'b1;
      e.at  = edge_no + 1;
      e.key = m_key;
      exp_q.push_back(e);
      n--;
    end
    m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
  endtask

  // Drive one cycle, advance the model over the coming edge, check outputs.
  task automatic cyc(input logic [3:0] kn, input logic ack, input logic r);
    key_n      = kn;
    ev.evt_ack = ack;
    rst        = r;
    model_step(kn, ack, r);
    @(negedge clk);
    chk("key_level", key_level, m_level);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("evt_valid", ev.evt_valid, m_valid);
    chk("evt_key", ev.evt_key, m_key);
  endtask

  // Monitor: every newly presented event is popped and compared.
  initial begin : monitor
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ev.evt_valid === 1'b1 && (!pv || ev.evt_ack === 1'b1)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got key %b at edge %0d, none expected", ev.evt_key, edge_no);
        end else begin
          e = exp_q.pop_front();
          if (e.at != edge_no || e.key !== ev.evt_key) begin
            failures++;
            $display("FAIL sb_event: got key %b at edge %0d expected key %b at edge %0d",
                     ev.evt_key, edge_no, e.key, e.at);
          end
        end
      end
      pv = (ev.evt_valid === 1'b1);
    end
  end

  initial begin : stim
    int         first_v;
    int         seen;
    int         dur;
    logic [3:0] kn;
    int         t[$];

    ev.evt_ack = 1'b0;
    repeat (3) cyc(4'hF, 1'b0, 1'b1);
    chk("reset_outputs", {key_level, drop_cnt, ev.evt_valid, ev.evt_key}, 17'd0);

    // Single press of up: event 10 cycles after the input edge
    first_v = -1;
    for (int c = 1; c <= 30; c++) begin
      cyc(4'b0111, 1'b0, 1'b0);
      if (ev.evt_valid === 1'b1 && first_v < 0) first_v = c;
    end
    chk("press_latency", first_v, 10);
    chk("press_level", key_level, 4'b1000);
    chk("press_key", ev.evt_key, 4'b1000);
    if (!RPT_EN) chk("press_single_event", drop_cnt, 0);
    cyc(4'hF, 1'b1, 1'b0);
    repeat (14) cyc(4'hF, 1'b0, 1'b0);
    chk("release_level", key_level, 4'b0000);

    // Bounce shorter than the debounce window
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(((c / 5) % 2) != 0 ? 4'hF : 4'b0111, 1'b0, 1'b0);
      seen = seen | int'(key_level) | int'(ev.evt_valid);
    end
    chk("bounce_ignored", seen, 0);
    repeat (12) cyc(4'hF, 1'b0, 1'b0);

    // Up and right together into an empty slot
    repeat (2) cyc(4'hF, 1'b0, 1'b1);
    repeat (12) cyc(4'b0110, 1'b0, 1'b0);
    chk("simul_key", ev.evt_key, 4'b1000);
    chk("simul_drop", drop_cnt, 1);
    cyc(4'hF, 1'b1, 1'b0);
    repeat (12) cyc(4'hF, 1'b0, 1'b0);

    // Ack in the same cycle as a new raise: reload with no bubble
    repeat (12) cyc(4'b1101, 1'b0, 1'b0);
    chk("left_key", ev.evt_key, 4'b0010);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc(4'b1001, c == 10, 1'b0);
      if (ev.evt_valid !== 1'b1) seen++;
    end
    chk("ack_reload_no_bubble", seen, 0);
    chk("ack_reload_key", ev.evt_key, 4'b0100);
    cyc(4'hF, 1'b1, 1'b0);
    repeat (12) cyc(4'hF, 1'b0, 1'b0);

    // 300 presses without ack: first event kept, drops saturate
    repeat (2) cyc(4'hF, 1'b0, 1'b1);
    for (int p = 0; p < 300; p++) begin
      repeat (10) cyc(4'b0111, 1'b0, 1'b0);
      repeat (10) cyc(4'hF, 1'b0, 1'b0);
    end
    chk("sat_key", ev.evt_key, 4'b1000);
    chk("sat_valid", ev.evt_valid, 1);
    chk("sat_drop", drop_cnt, 255);
    cyc(4'hF, 1'b1, 1'b0);

    // Randomized keys, acks and occasional resets
    for (int g = 0; g < 400; g++) begin
      kn  = 4'($urandom);
      dur = $urandom_range(1, 25);
      for (int d = 0; d < dur; d++)
        cyc(kn, 1'($urandom % 2), $urandom_range(0, 399) == 0);
    end

    // Long hold of left with every event acked
    repeat (2) cyc(4'hF, 1'b0, 1'b1);
    t.delete();
    for (int c = 0; c < 60; c++) begin
      cyc(4'b1101, 1'b1, 1'b0);
      if (ev.evt_valid === 1'b1) t.push_back(c);
    end
    if (RPT_EN) begin
      if (t.size() < 4) chk("rpt_count", t.size(), 4);
      else begin
        chk("rpt_first", t[1] - t[0], 20);
        chk("rpt_second", t[2] - t[0], 26);
        chk("rpt_third", t[3] - t[0], 32);
      end
    end else begin
      chk("no_repeat", t.size(), 1);
    end
    cyc(4'b1101, 1'b0, 1'b1);
    chk("rst_mid_hold", {key_level, drop_cnt, ev.evt_valid, ev.evt_key}, 17'd0);
    first_v = -1;
    for (int c = 1; c <= 20; c++) begin
      cyc(4'b1101, 1'b0, 1'b0);
      if (ev.evt_valid === 1'b1 && first_v < 0) first_v = c;
    end
    chk("post_reset_latency", first_v, 10);
    repeat (12) cyc(4'hF, 1'b1, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
